keypad_scanner: RTL and testbench

//   Drives a 4x4 matrix keypad and turns one debounced key press into a key code and a one-cycle
//   key_valid pulse. This is the entry side of the safe's digit interface. It feeds the lock core in

---
 rtl/keypad_scanner.sv | 168 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces a single key
// and reports its code with a one-cycle key_valid pulse per press.
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV     = 16'd4,
  parameter logic [3:0]  DEBOUNCE_CNT = 4'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  state_t      state, state_nxt;
  logic [3:0]  row_meta, row_s;
  logic [15:0] div;
  logic        tick;
  logic [1:0]  col, col_nxt;
  logic [1:0]  lat_idx, lat_idx_nxt;
  logic [3:0]  lat_pattern;
  logic [3:0]  deb_cnt, deb_cnt_nxt;
  logic [3:0]  rel_cnt, rel_cnt_nxt;
  logic [3:0]  key_code_nxt;
  logic        key_valid_nxt;
  logic        single_low;
  logic [1:0]  low_idx;
  logic        accept;
  logic [1:0]  accept_row;

  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = 4'd10;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = 4'd11;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = 4'd12;
      4'hC:    code = 4'd14;
      4'hD:    code = 4'd0;
      4'hE:    code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Rows are asynchronous to clk, so nothing looks at them before two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_s    <= row_meta;
    end
  end

  assign tick = (div == SCAN_DIV - 16'd1);

  always_ff @(posedge clk) begin
    if (rst)       div <= 16'd0;
    else if (tick) div <= 16'd0;
    else           div <= div + 16'd1;
  end

  always_comb begin
    single_low = 1'b0;
    low_idx    = 2'd0;
    case (row_s)
      4'b1110: begin single_low = 1'b1; low_idx = 2'd0; end
      4'b1101: begin single_low = 1'b1; low_idx = 2'd1; end
      4'b1011: begin single_low = 1'b1; low_idx = 2'd2; end
      4'b0111: begin single_low = 1'b1; low_idx = 2'd3; end
      default: ;
    endcase
  end

  assign lat_pattern = ~(4'b0001 << lat_idx);
  assign col_out     = ~(4'b0001 << col);
  assign key_held    = (state == PRESSED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col       <= 2'd0;
      lat_idx   <= 2'd0;
      deb_cnt   <= 4'd0;
      rel_cnt   <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      lat_idx   <= lat_idx_nxt;
      deb_cnt   <= deb_cnt_nxt;
      rel_cnt   <= rel_cnt_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
    end
  end

  // The column only moves on a tick that does not start or continue a press.
  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    lat_idx_nxt   = lat_idx;
    deb_cnt_nxt   = deb_cnt;
    rel_cnt_nxt   = rel_cnt;
    key_code_nxt  = key_code;
    key_valid_nxt = 1'b0;
    accept        = 1'b0;
    accept_row    = lat_idx;
    if (tick) begin
      case (state)
        SCAN: begin
          if (single_low) begin
            lat_idx_nxt = low_idx;
            deb_cnt_nxt = 4'd1;
            accept_row  = low_idx;
            if (DEBOUNCE_CNT <= 4'd1) accept = 1'b1;
            else                      state_nxt = DEBOUNCE;
          end else begin
            col_nxt = col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_s == lat_pattern) begin
            deb_cnt_nxt = deb_cnt + 4'd1;
            if (deb_cnt_nxt >= DEBOUNCE_CNT) accept = 1'b1;
          end else begin
            state_nxt = SCAN;
            col_nxt   = col + 2'd1;
          end
        end
        PRESSED: begin
          if (row_s == 4'hF) begin
            rel_cnt_nxt = rel_cnt + 4'd1;
            if (rel_cnt_nxt >= DEBOUNCE_CNT) begin
              state_nxt   = SCAN;
              rel_cnt_nxt = 4'd0;
              col_nxt     = col + 2'd1;
            end
          end else begin
            rel_cnt_nxt = 4'd0;
          end
        end
        default: state_nxt = SCAN;
      endcase
      if (accept) begin
        state_nxt     = PRESSED;
        rel_cnt_nxt   = 4'd0;
        key_code_nxt  = map_key(accept_row, col);
        key_valid_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from the scanned columns,
// a spec-level model predicts every output each cycle, plus literal spot checks.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  logic [3:0] m_s0, m_s1, m_lat, m_code;
  int         m_div, m_col, m_mode, m_cnt, m_rcnt, m_row;
  bit         m_valid;
  bit         m_ready = 1'b0;

  keypad_scanner #(.SCAN_DIV(16'd4), .DEBOUNCE_CNT(4'd3)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // keys bit r*4+c pulls row r low whenever column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col_out[c] === 1'b0) row_in[r] = 1'b0;
  end

  function automatic logic [3:0] keymap(input int idx);
    case (idx)
      0: return 4'd1;   1: return 4'd2;   2: return 4'd3;   3: return 4'd10;
      4: return 4'd4;   5: return 4'd5;   6: return 4'd6;   7: return 4'd11;
      8: return 4'd7;   9: return 4'd8;  10: return 4'd9;  11: return 4'd12;
      12: return 4'd14; 13: return 4'd0; 14: return 4'd15; default: return 4'd13;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Mode 0 = scanning, 1 = confirming a press, 2 = key accepted and held.
  task automatic modelStep();
    logic [3:0] s;
    int lows;
    int lowRow;
    bit enter;
    if (rst === 1'b1) begin
      m_s0 = 4'hF; m_s1 = 4'hF; m_div = 0; m_col = 0; m_mode = 0;
      m_cnt = 0; m_rcnt = 0; m_row = 0; m_lat = 4'hF; m_code = 4'd0;
      m_valid = 1'b0; m_ready = 1'b1;
      return;
    end
    s = m_s1; m_s1 = m_s0; m_s0 = row_in;
    m_valid = 1'b0;
    enter = 1'b0;
    if (m_div == SCAN_DIV - 1) begin
      lows = 0; lowRow = 0;
      for (int r = 0; r < 4; r++) if (!s[r]) begin lows++; lowRow = r; end
      case (m_mode)
        0: begin
          if (lows == 1) begin
            m_row = lowRow; m_cnt = 1; m_lat = s;
            if (m_cnt >= DEB) enter = 1'b1; else m_mode = 1;
          end else m_col = (m_col + 1) % 4;
        end
        1: begin
          if (s == m_lat) begin
            m_cnt++;
            if (m_cnt >= DEB) enter = 1'b1;
          end else begin
            m_mode = 0; m_col = (m_col + 1) % 4;
          end
        end
        default: begin
          if (s == 4'hF) begin
            m_rcnt++;
            if (m_rcnt >= DEB) begin m_mode = 0; m_rcnt = 0; m_col = (m_col + 1) % 4; end
          end else m_rcnt = 0;
        end
      endcase
      if (enter) begin
        m_mode = 2; m_rcnt = 0; m_code = keymap(m_row * 4 + m_col); m_valid = 1'b1;
      end
    end
    m_div = (m_div + 1) % SCAN_DIV;
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    logic [3:0] ec;
    @(negedge clk);
    if (m_ready) begin
      ec = 4'hF;
      ec[m_col] = 1'b0;
      checkOutput("model col_out", col_out, ec);
      checkOutput("model key_code", key_code, m_code);
      checkOutput("model key_valid", {3'b000, key_valid}, {3'b000, m_valid});
      checkOutput("model key_held", {3'b000, key_held}, {3'b000, m_mode == 2});
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) pulses++;
  end

  task automatic applyStimulus(input logic [15:0] k, input int cycles);
    keys = k;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitHeld(input logic level, input int budget, input string name);
    int n = 0;
    while (key_held !== level && n < budget) begin @(negedge clk); n++; end
    checkOutput(name, {3'b000, key_held}, {3'b000, level});
  endtask

  task automatic waitColumnEntry(input logic [3:0] c, input int budget);
    int n = 0;
    while (col_out === c && n < budget) begin @(negedge clk); n++; end
    n = 0;
    while (col_out !== c && n < budget) begin @(negedge clk); n++; end
    checkOutput("column reached", col_out, c);
  endtask

  initial begin
    int base;
    keys = 16'h0000;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset col_out", col_out, 4'b1110);
    checkOutput("reset key_code", key_code, 4'd0);
    checkOutput("reset key_valid", {3'b000, key_valid}, 4'd0);
    checkOutput("reset key_held", {3'b000, key_held}, 4'd0);
    rst = 1'b0;

    // Idle scan: four cycles per column.
    applyStimulus(16'h0000, 3);
    checkOutput("idle col0", col_out, 4'b1110);
    applyStimulus(16'h0000, 1);
    checkOutput("idle col1", col_out, 4'b1101);
    applyStimulus(16'h0000, 4);
    checkOutput("idle col2", col_out, 4'b1011);
    applyStimulus(16'h0000, 4);
    checkOutput("idle col3", col_out, 4'b0111);
    applyStimulus(16'h0000, 4);
    checkOutput("idle wrap", col_out, 4'b1110);

    // Key '5' held, then released.
    base = pulses;
    applyStimulus(16'h0020, 40);
    checkOutput("5 pulses", 4'(pulses - base), 4'd1);
    checkOutput("5 code", key_code, 4'd5);
    checkOutput("5 held", {3'b000, key_held}, 4'd1);
    applyStimulus(16'h0000, 6);
    checkOutput("5 held after release", {3'b000, key_held}, 4'd1);
    applyStimulus(16'h0000, 14);
    checkOutput("5 released", {3'b000, key_held}, 4'd0);

    // '#' seen for only two ticks of its column.
    waitColumnEntry(4'b1011, 40);
    base = pulses;
    applyStimulus(16'h4000, 8);
    applyStimulus(16'h0000, 12);
    checkOutput("# short pulses", 4'(pulses - base), 4'd0);
    checkOutput("# short code", key_code, 4'd5);

    // '1' and '4' together, then '4' released.
    base = pulses;
    applyStimulus(16'h0011, 40);
    checkOutput("1+4 pulses", 4'(pulses - base), 4'd0);
    checkOutput("1+4 held", {3'b000, key_held}, 4'd0);
    applyStimulus(16'h0001, 40);
    checkOutput("1 pulses", 4'(pulses - base), 4'd1);
    checkOutput("1 code", key_code, 4'd1);
    applyStimulus(16'h0000, 20);

    // '0' twice, then a long hold.
    base = pulses;
    applyStimulus(16'h2000, 40);
    applyStimulus(16'h0000, 20);
    applyStimulus(16'h2000, 40);
    checkOutput("0 twice pulses", 4'(pulses - base), 4'd2);
    checkOutput("0 code", key_code, 4'd0);
    applyStimulus(16'h2000, 200);
    checkOutput("0 long hold pulses", 4'(pulses - base), 4'd2);
    checkOutput("0 long hold held", {3'b000, key_held}, 4'd1);
    applyStimulus(16'h0000, 20);

    // Reset in the middle of a held '5'.
    keys = 16'h0020;
    waitHeld(1'b1, 60, "5 held before reset");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-press reset held", {3'b000, key_held}, 4'd0);
    checkOutput("mid-press reset col", col_out, 4'b1110);
    checkOutput("mid-press reset code", key_code, 4'd0);
    rst = 1'b0;
    base = pulses;
    applyStimulus(16'h0020, 40);
    checkOutput("5 after reset pulses", 4'(pulses - base), 4'd1);
    checkOutput("5 after reset code", key_code, 4'd5);
    applyStimulus(16'h0000, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
